// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver
//   SPI Mode 3 slave receiver for an OLED controller front end. Bytes shifted
//   in MSB first while chip select is low are paired with the D/C line value
//   sampled on the last clock and queued in a small FIFO for the consumer.
//   All SPI inputs are asynchronous and are synchronised into the sclk domain.
//
// Parameters
//   FIFO_DEPTH   output FIFO entries (power of two, >= 2)
//
// Ports
//   sclk         system clock, rising edge
//   rst_n        synchronous active-low reset
//   spi_sck      SPI clock (Mode 3, idles high)
//   spi_cs       chip select, active low
//   spi_mosi     serial data, MSB first
//   spi_dc       D/C line (0 = command, 1 = data)
//   out_valid    head FIFO entry available
//   out_data     head entry byte
//   out_dc       D/C value captured with the head byte
//   out_ready    consumer pops the head when out_valid && out_ready
//   busy         synchronised chip select is low
//   overflow     sticky: a completed byte was dropped (FIFO full)
//   frame_err    sticky: chip select rose mid-byte
//   clear_err    single-cycle pulse clearing overflow and frame_err
//
// Optional feature (macro OLED_SPI_RX_STATS_EN)
//   cmd_count    count of accepted command bytes (wraps)
//   data_count   count of accepted data bytes (wraps)

module oled_spi_receiver #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_dc,
    input  logic        out_ready,
    output logic        busy,
    output logic        overflow,
    output logic        frame_err,
    input  logic        clear_err
`ifdef OLED_SPI_RX_STATS_EN
    ,
    output logic [15:0] cmd_count,
    output logic [15:0] data_count
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {StIdle, StShift} state_e;

    // ------------------------------------------------------------------
    // Input synchronisers. sck gets a third stage for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] sck_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [1:0] dc_sync;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            sck_sync  <= 3'b000;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
        end
    end

    logic cs_s;
    logic mosi_s;
    logic dc_s;
    logic sck_rise;

    assign cs_s     = cs_sync[1];
    assign mosi_s   = mosi_sync[1];
    assign dc_s     = dc_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];

    // ------------------------------------------------------------------
    // Receive FSM and shifter. A completed byte is staged in push_* for
    // one cycle before the FIFO write.
    // ------------------------------------------------------------------
    state_e     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       push_q;
    logic [7:0] push_data_q;
    logic       push_dc_q;
    logic       frame_err_q;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            push_dc_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first so a coincident new error still leaves the flag set.
            if (clear_err) begin
                frame_err_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (!cs_s) begin
                        state_q   <= StShift;
                        bit_cnt_q <= 3'd0;
                        shift_q   <= 8'h00;
                    end
                end
                StShift: begin
                    if (cs_s) begin
                        state_q   <= StIdle;
                        bit_cnt_q <= 3'd0;
                        if (bit_cnt_q != 3'd0) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_q   <= {shift_q[6:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            push_q      <= 1'b1;
                            push_data_q <= {shift_q[6:0], mosi_s};
                            push_dc_q   <= dc_s;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO. A push into a full FIFO is still accepted when the
    // consumer pops in the same cycle.
    // ------------------------------------------------------------------
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          full;
    logic          pop;
    logic          do_push;

    assign full    = (count_q == DEPTH_C);
    assign pop     = out_valid & out_ready;
    assign do_push = push_q & (~full | pop);

`ifdef OLED_SPI_RX_STATS_EN
    logic [15:0] cmd_count_q;
    logic [15:0] data_count_q;
`endif

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
`ifdef OLED_SPI_RX_STATS_EN
            cmd_count_q  <= 16'h0000;
            data_count_q <= 16'h0000;
`endif
        end else begin
            overflow_q <= (overflow_q & ~clear_err) | (push_q & full & ~pop);
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_dc_q, push_data_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
`ifdef OLED_SPI_RX_STATS_EN
                if (push_dc_q) begin
                    data_count_q <= data_count_q + 16'd1;
                end else begin
                    cmd_count_q <= cmd_count_q + 16'd1;
                end
`endif
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !pop) begin
                count_q <= count_q + (AW + 1)'(1);
            end else if (!do_push && pop) begin
                count_q <= count_q - (AW + 1)'(1);
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q][7:0];
    assign out_dc    = mem_q[rd_ptr_q][8];
    assign busy      = ~cs_s;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

`ifdef OLED_SPI_RX_STATS_EN
    assign cmd_count  = cmd_count_q;
    assign data_count = data_count_q;
`endif

endmodule
